// File: rtl/ram_test_bist_if.sv
// ram_test_bist_if -- control/status bundle for the RAM BIST.
//   master : drives start_i, mode_i, passes_i, seed_i, err_inject_i;
//            observes busy/done/pass, pass index and error statistics.
//   slave  : the BIST itself (directions mirrored).
interface ram_test_bist_if #(
   parameter int CHUNK_W    = 32,
   parameter int CHUNK_CNT  = 4,
   parameter int RAM_ADDR_W = 4,
   parameter int ERR_CNT_W  = 16
);
   logic                  start_i;
   logic [1:0]            mode_i;
   logic [7:0]            passes_i;
   logic [CHUNK_W-1:0]    seed_i;
   logic                  err_inject_i;
   logic                  busy_o;
   logic                  done_o;
   logic                  pass_o;
   logic [7:0]            cur_pass_o;
   logic [ERR_CNT_W-1:0]  err_cnt_o;
   logic [CHUNK_CNT-1:0]  err_chunk_o;
   logic                  first_err_valid_o;
   logic [RAM_ADDR_W-1:0] first_err_addr_o;

   modport master (
      output start_i, mode_i, passes_i, seed_i, err_inject_i,
      input  busy_o, done_o, pass_o, cur_pass_o, err_cnt_o, err_chunk_o,
             first_err_valid_o, first_err_addr_o
   );
   modport slave (
      input  start_i, mode_i, passes_i, seed_i, err_inject_i,
      output busy_o, done_o, pass_o, cur_pass_o, err_cnt_o, err_chunk_o,
             first_err_valid_o, first_err_addr_o
   );
endinterface

// File: rtl/ram_test_bist.sv
// ram_test_bist -- start-triggered multi-pass fill/check BIST around an
// inferred simple dual-port RAM (2**RAM_ADDR_W words of CHUNK_CNT x CHUNK_W).
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset
//   bus     : ram_test_bist_if.slave -- start/config in, status/statistics out
// ram_test_bist_lane generates one chunk of the pattern and compares one
// chunk of returned read data.

module ram_test_bist_lane #(
   parameter int CHUNK_W    = 32,
   parameter int RAM_ADDR_W = 4,
   parameter int LANE       = 0
) (
   input  logic [1:0]            mode_i,
   input  logic [CHUNK_W-1:0]    seed_i,
   input  logic [RAM_ADDR_W-1:0] addr_i,
   input  logic [7:0]            pass_i,
   input  logic [CHUNK_W-1:0]    rd_i,
   input  logic [CHUNK_W-1:0]    exp_i,
   output logic [CHUNK_W-1:0]    pat_o,
   output logic                  mism_o
);
   logic [CHUNK_W-1:0] s;

   always_comb begin
      s = seed_i + CHUNK_W'(addr_i) + CHUNK_W'(LANE) + CHUNK_W'(pass_i);
      case (mode_i)
         2'd1:    pat_o = ~s;
         2'd2:    pat_o = CHUNK_W'(1) << (s % CHUNK_W);
         default: pat_o = s;   // mode 3 aliases incrementing
      endcase
   end

   assign mism_o = (rd_i != exp_i);
endmodule

module ram_test_bist #(
   parameter int RAM_ADDR_W = 4,
   parameter int CHUNK_W    = 32,
   parameter int CHUNK_CNT  = 4,
   parameter int RD_LATENCY = 1,
   parameter int ERR_CNT_W  = 16
) (
   input logic            clk_i,
   input logic            rst_n_i,
   ram_test_bist_if.slave bus
);
   localparam int DEPTH = 2**RAM_ADDR_W;
   localparam logic [RAM_ADDR_W-1:0] ADDR_LAST = RAM_ADDR_W'(DEPTH-1);
   localparam logic [1:0] DRN_LAST = 2'(RD_LATENCY-1);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_CHECK, S_DRAIN, S_DONE} state_t;
   typedef logic [CHUNK_CNT-1:0][CHUNK_W-1:0] word_t;
   typedef struct packed {
      logic [1:0]         mode;
      logic [7:0]         passes;   // already forced to >= 1
      logic [CHUNK_W-1:0] seed;
      logic               inject;
   } cfg_t;
   typedef struct packed {
      word_t                 exp;
      logic [RAM_ADDR_W-1:0] addr;
   } chk_t;

   state_t                state_q, state_d;
   cfg_t                  cfg_q;
   logic                  start_ok, rd_en, last_pass, word_fail;
   logic [RAM_ADDR_W-1:0] addr_q;
   logic [1:0]            drn_q;
   logic [7:0]            cur_pass_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q;
   logic [CHUNK_CNT-1:0]  err_chunk_q, mism;
   logic                  first_vld_q;
   logic [RAM_ADDR_W-1:0] first_addr_q;

   word_t                 mem [DEPTH];
   word_t                 pat_w, wr_word;
   word_t                 rd_pipe  [1:RD_LATENCY];
   chk_t                  chk_pipe [1:RD_LATENCY];
   logic [RD_LATENCY:1]   vld_pipe;

   assign rd_en     = (state_q == S_CHECK);
   assign last_pass = ({1'b0, cur_pass_q} + 9'd1) >= {1'b0, cfg_q.passes};
   assign word_fail = vld_pipe[RD_LATENCY] && (|mism);

   // FILL and CHECK share one address counter, so pattern generation is
   // shared too; only the write copy carries the injected fault.
   for (genvar g = 0; g < CHUNK_CNT; g++) begin : g_lane
      ram_test_bist_lane #(.CHUNK_W(CHUNK_W), .RAM_ADDR_W(RAM_ADDR_W), .LANE(g)) u_lane (
         .mode_i (cfg_q.mode),
         .seed_i (cfg_q.seed),
         .addr_i (addr_q),
         .pass_i (cur_pass_q),
         .rd_i   (rd_pipe[RD_LATENCY][g]),
         .exp_i  (chk_pipe[RD_LATENCY].exp[g]),
         .pat_o  (pat_w[g]),
         .mism_o (mism[g])
      );
   end

   always_comb begin
      wr_word = pat_w;
      if (cfg_q.inject && addr_q == '0) wr_word[0][0] = ~pat_w[0][0];
   end

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: if (bus.start_i) begin
            state_d  = S_FILL;
            start_ok = 1'b1;
         end
         S_FILL:  if (addr_q == ADDR_LAST) state_d = S_CHECK;
         S_CHECK: if (addr_q == ADDR_LAST) state_d = S_DRAIN;
         S_DRAIN: if (drn_q == DRN_LAST) state_d = last_pass ? S_DONE : S_FILL;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         cfg_q        <= '0;
         addr_q       <= '0;
         drn_q        <= '0;
         cur_pass_q   <= '0;
         vld_pipe     <= '0;
         err_cnt_q    <= '0;
         err_chunk_q  <= '0;
         first_vld_q  <= 1'b0;
         first_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         vld_pipe <= RD_LATENCY'({vld_pipe, rd_en});
         addr_q   <= (state_q == S_FILL || state_q == S_CHECK) ? addr_q + 1'b1 : '0;
         drn_q    <= (state_q == S_DRAIN) ? drn_q + 2'd1 : 2'd0;
         if (state_q == S_DRAIN && drn_q == DRN_LAST && !last_pass)
            cur_pass_q <= cur_pass_q + 8'd1;
         if (start_ok) begin
            cfg_q.mode   <= bus.mode_i;
            cfg_q.passes <= (bus.passes_i == 8'd0) ? 8'd1 : bus.passes_i;
            cfg_q.seed   <= bus.seed_i;
            cfg_q.inject <= bus.err_inject_i;
            cur_pass_q   <= '0;
            err_cnt_q    <= '0;
            err_chunk_q  <= '0;
            first_vld_q  <= 1'b0;
            first_addr_q <= '0;
         end else if (word_fail) begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            err_chunk_q <= err_chunk_q | mism;
            if (!first_vld_q) begin
               first_vld_q  <= 1'b1;
               first_addr_q <= chk_pipe[RD_LATENCY].addr;
            end
         end
      end
   end

   // RAM array and read pipeline carry no reset; validity rides on vld_pipe.
   always_ff @(posedge clk_i) begin
      if (state_q == S_FILL) mem[addr_q] <= wr_word;
      if (rd_en) rd_pipe[1] <= mem[addr_q];
      chk_pipe[1].exp  <= pat_w;
      chk_pipe[1].addr <= addr_q;
      for (int k = 2; k <= RD_LATENCY; k++) begin
         rd_pipe[k]  <= rd_pipe[k-1];
         chk_pipe[k] <= chk_pipe[k-1];
      end
   end

   assign bus.busy_o            = (state_q == S_FILL) || (state_q == S_CHECK) || (state_q == S_DRAIN);
   assign bus.done_o            = (state_q == S_DONE);
   assign bus.pass_o            = (state_q == S_DONE) && (err_cnt_q == '0);
   assign bus.cur_pass_o        = cur_pass_q;
   assign bus.err_cnt_o         = err_cnt_q;
   assign bus.err_chunk_o       = err_chunk_q;
   assign bus.first_err_valid_o = first_vld_q;
   assign bus.first_err_addr_o  = first_addr_q;
endmodule

// File: tb/tb_ram_test_bist.sv
// Bench for ram_test_bist: dut0 uses default parameters, dut1 uses
// ERR_CNT_W=2 / RD_LATENCY=3 for saturation and latency coverage.
module tb_ram_test_bist;
   localparam int AW = 4, CW = 32, CC = 4, DEPTH = 16;
   localparam int CYC0 = 2*DEPTH + 1;
   localparam int CYC1 = 2*DEPTH + 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   ram_test_bist_if #(.CHUNK_W(CW), .CHUNK_CNT(CC), .RAM_ADDR_W(AW), .ERR_CNT_W(16)) bus0 ();
   ram_test_bist_if #(.CHUNK_W(CW), .CHUNK_CNT(CC), .RAM_ADDR_W(AW), .ERR_CNT_W(2))  bus1 ();

   ram_test_bist #(.RAM_ADDR_W(AW), .CHUNK_W(CW), .CHUNK_CNT(CC), .RD_LATENCY(1), .ERR_CNT_W(16))
      dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
   ram_test_bist #(.RAM_ADDR_W(AW), .CHUNK_W(CW), .CHUNK_CNT(CC), .RD_LATENCY(3), .ERR_CNT_W(2))
      dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

   // Reference pattern straight from the pattern rules.
   function automatic logic [31:0] model_pat(input logic [1:0] mode, input logic [31:0] seed,
                                             input int a, input int g, input int p);
      logic [31:0] s;
      s = seed + 32'(a) + 32'(g) + 32'(p);
      case (mode)
         2'd1:    return ~s;
         2'd2:    return 32'd1 << (s % 32);
         default: return s;
      endcase
   endfunction

   // One full run on dut0, checked end to end. restart_at > 0 pulses start
   // again that many cycles after busy rises (must be ignored).
   task automatic run0(input string name, input logic [1:0] mode, input logic [7:0] passes,
                       input logic [31:0] seed, input logic inj, input int restart_at);
      int p_eff, exp_n, n, bad, membad;
      logic [31:0] want;
      logic [15:0] cnt0;
      p_eff = (passes == 0) ? 1 : int'(passes);
      exp_n = p_eff * CYC0;
      @(negedge clk);
      bus0.mode_i = mode; bus0.passes_i = passes; bus0.seed_i = seed;
      bus0.err_inject_i = inj; bus0.start_i = 1'b1;
      @(negedge clk);
      bus0.start_i = 1'b0;
      // scramble config inputs: the run must use the latched values
      bus0.mode_i = 2'($urandom); bus0.passes_i = 8'($urandom); bus0.seed_i = $urandom;
      bus0.err_inject_i = 1'($urandom);
      n = 0; bad = 0;
      while (bus0.done_o !== 1'b1 && n <= exp_n + 40) begin
         if (bus0.busy_o !== 1'b1 || bus0.cur_pass_o !== 8'(n / CYC0)) bad++;
         @(negedge clk); n++;
         bus0.start_i = (n == restart_at);
      end
      bus0.start_i = 1'b0;
      checks++; if (n != exp_n) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_n); end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s busy/cur_pass: %0d bad cycles want 0", name, bad); end
      checks++; if (bus0.busy_o !== 1'b0 || bus0.cur_pass_o !== 8'(p_eff-1)) begin
         errors++; $display("FAIL %s end state: busy=%b cur_pass=%0d want 0/%0d", name, bus0.busy_o, bus0.cur_pass_o, p_eff-1); end
      checks++; if (bus0.err_cnt_o !== (inj ? 16'(p_eff) : 16'd0)) begin
         errors++; $display("FAIL %s err_cnt: got %0d want %0d", name, bus0.err_cnt_o, inj ? p_eff : 0); end
      checks++; if (bus0.err_chunk_o !== (inj ? 4'b0001 : 4'b0000)) begin
         errors++; $display("FAIL %s err_chunk: got %b want %b", name, bus0.err_chunk_o, inj ? 4'b0001 : 4'b0000); end
      checks++; if (bus0.first_err_valid_o !== inj || bus0.first_err_addr_o !== 4'd0) begin
         errors++; $display("FAIL %s first_err: got %b/%0d want %b/0", name, bus0.first_err_valid_o, bus0.first_err_addr_o, inj); end
      checks++; if (bus0.pass_o !== !inj) begin
         errors++; $display("FAIL %s pass: got %b want %b", name, bus0.pass_o, !inj); end
      membad = 0;
      for (int a = 0; a < DEPTH; a++)
         for (int g = 0; g < CC; g++) begin
            want = model_pat(mode, seed, a, g, p_eff-1);
            if (inj && a == 0 && g == 0) want[0] = ~want[0];
            if (dut0.mem[a][g] !== want) membad++;
         end
      checks++; if (membad != 0) begin errors++; $display("FAIL %s ram contents: %0d bad chunks want 0", name, membad); end
      cnt0 = bus0.err_cnt_o;
      repeat (4) @(negedge clk);
      checks++; if (bus0.done_o !== 1'b1 || bus0.err_cnt_o !== cnt0) begin
         errors++; $display("FAIL %s done hold: done=%b err_cnt=%0d want 1/%0d", name, bus0.done_o, bus0.err_cnt_o, cnt0); end
   endtask

   task automatic run1(input string name, input logic [7:0] passes, input logic inj);
      int p_eff, exp_n, n, sat;
      p_eff = (passes == 0) ? 1 : int'(passes);
      exp_n = p_eff * CYC1;
      sat = inj ? ((p_eff > 3) ? 3 : p_eff) : 0;
      @(negedge clk);
      bus1.mode_i = 2'($urandom); bus1.passes_i = passes; bus1.seed_i = $urandom;
      bus1.err_inject_i = inj; bus1.start_i = 1'b1;
      @(negedge clk);
      bus1.start_i = 1'b0;
      n = 0;
      while (bus1.done_o !== 1'b1 && n <= exp_n + 40) begin @(negedge clk); n++; end
      checks++; if (n != exp_n) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_n); end
      checks++; if (bus1.err_cnt_o !== 2'(sat)) begin errors++; $display("FAIL %s err_cnt: got %0d want %0d", name, bus1.err_cnt_o, sat); end
      checks++; if (bus1.err_chunk_o !== {3'b000, inj} || bus1.pass_o !== !inj) begin
         errors++; $display("FAIL %s chunk/pass: got %b/%b want %b/%b", name, bus1.err_chunk_o, bus1.pass_o, {3'b000, inj}, !inj); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if ({bus0.busy_o, bus0.done_o, bus0.pass_o, bus0.cur_pass_o, bus0.err_cnt_o, bus0.err_chunk_o,
                     bus0.first_err_valid_o, bus0.first_err_addr_o} !== '0) begin
         errors++; $display("FAIL reset outputs: busy=%b done=%b err_cnt=%0d want all 0", bus0.busy_o, bus0.done_o, bus0.err_cnt_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_midrun_reset();
      int n;
      @(negedge clk);
      bus0.mode_i = 2'd1; bus0.passes_i = 8'd2; bus0.seed_i = $urandom;
      bus0.err_inject_i = 1'b1; bus0.start_i = 1'b1;
      @(negedge clk);
      bus0.start_i = 1'b0;
      n = 0;
      while (n < 19) begin @(negedge clk); n++; end
      rst_n = 1'b0;
      #1;
      checks++; if ({bus0.busy_o, bus0.done_o, bus0.pass_o, bus0.cur_pass_o, bus0.err_cnt_o, bus0.err_chunk_o,
                     bus0.first_err_valid_o, bus0.first_err_addr_o} !== '0) begin
         errors++; $display("FAIL midrun reset: busy=%b err_cnt=%0d want 0/0", bus0.busy_o, bus0.err_cnt_o); end
      @(negedge clk);
      rst_n = 1'b1;
      run0("after_reset", 2'($urandom), 8'd1, $urandom, 1'b0, -1);
   endtask

   initial begin
      bus0.start_i = 1'b0; bus0.mode_i = '0; bus0.passes_i = '0; bus0.seed_i = '0; bus0.err_inject_i = 1'b0;
      bus1.start_i = 1'b0; bus1.mode_i = '0; bus1.passes_i = '0; bus1.seed_i = '0; bus1.err_inject_i = 1'b0;
      test_reset();
      // defaults: incrementing pattern, single pass
      run0("default", 2'd0, 8'd1, 32'd0, 1'b0, -1);
      checks++; if (dut0.mem[5][2] !== 32'd7) begin errors++; $display("FAIL probe addr5 chunk2: got %0d want 7", dut0.mem[5][2]); end
      run0("walk_one", 2'd2, 8'd3, 32'd30, 1'b0, -1);
      run0("inv_inject", 2'd1, 8'd4, $urandom, 1'b1, -1);
      run0("zero_passes_restart", 2'd0, 8'd0, $urandom, 1'b0, 5);
      test_midrun_reset();
      for (int i = 0; i < 4; i++)
         run0("random", 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), -1);
      run1("saturate", 8'd8, 1'b1);
      run1("lat3_clean", 8'($urandom_range(1, 3)), 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
